// File: rtl/retro_paint_pkg.sv
// Shared paint-path types: default command/coordinate widths, command codes and the
// {cmd,x,y} word carried from HID sources to the paint engine.
package retro_paint_pkg;

    localparam int DEF_CMD_W   = 3;
    localparam int DEF_COORD_W = 6;

    localparam logic [DEF_CMD_W-1:0] CMD_NOP   = 3'd0;
    localparam logic [DEF_CMD_W-1:0] CMD_DRAW  = 3'd1;
    localparam logic [DEF_CMD_W-1:0] CMD_ERASE = 3'd2;
    localparam logic [DEF_CMD_W-1:0] CMD_MOVE  = 3'd3;
    localparam logic [DEF_CMD_W-1:0] CMD_CLEAR = 3'd4;
    localparam logic [DEF_CMD_W-1:0] CMD_FILL  = 3'd5;

    typedef struct packed {
        logic [DEF_CMD_W-1:0]   cmd;
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
    } cmd_word_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous per-channel command FIFO; a push on a full FIFO is taken only when a pop
// frees a slot in the same cycle.
module cmd_fifo
    import retro_paint_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_rd_en;
    logic             w_wr_en;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = pop && !empty;
    assign w_wr_en = push && (!full || w_rd_en);
    assign dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hid_cmd_arbiter.sv
// N-channel paint command merger: per-channel FIFOs, round-robin grant, valid/ready output,
// sticky overflow and stretched activity LED. Define COORD_CLAMP_EN to clamp x/y on push.
module hid_cmd_arbiter
    import retro_paint_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int CMD_W      = DEF_CMD_W,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_X      = 63,
    parameter int MAX_Y      = 63,
    parameter int LED_HOLD   = 2500000,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*CMD_W-1:0]   in_cmd,
    input  logic [N_CH*COORD_W-1:0] in_x,
    input  logic [N_CH*COORD_W-1:0] in_y,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [CMD_W-1:0]        out_cmd,
    output logic [COORD_W-1:0]      out_x,
    output logic [COORD_W-1:0]      out_y,
    output logic [CH_W-1:0]         out_ch,
    output logic [N_CH-1:0]         overflow,
    output logic                    led
);

    localparam int WORD_W = CMD_W + 2*COORD_W;
    localparam int LED_W  = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
`ifdef COORD_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic [N_CH-1:0]   w_full;
    logic [N_CH-1:0]   w_empty;
    logic [N_CH-1:0]   w_pop;
    logic [WORD_W-1:0] w_dout [N_CH];
    logic              w_load;
    logic              w_any;
    logic              w_hit;
    logic              w_accept;
    logic [CH_W-1:0]   w_grant;
    logic [CH_W-1:0]   w_idx;
    logic [CH_W:0]     w_sum;
    logic [CH_W-1:0]   w_next_rr;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [LED_W-1:0]  r_led_cnt;

    assign w_load    = !out_valid || out_ready;
    assign w_next_rr = (w_grant == CH_W'(N_CH-1)) ? '0 : w_grant + CH_W'(1);
    assign w_accept  = |(in_valid & (~w_full | w_pop));

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [COORD_W-1:0] w_raw_x;
        logic [COORD_W-1:0] w_raw_y;
        logic [COORD_W-1:0] w_x;
        logic [COORD_W-1:0] w_y;

        assign w_raw_x = in_x[i*COORD_W +: COORD_W];
        assign w_raw_y = in_y[i*COORD_W +: COORD_W];
        assign w_x     = (CLAMP_EN && (w_raw_x > COORD_W'(MAX_X))) ? COORD_W'(MAX_X) : w_raw_x;
        assign w_y     = (CLAMP_EN && (w_raw_y > COORD_W'(MAX_Y))) ? COORD_W'(MAX_Y) : w_raw_y;
        assign w_pop[i] = w_load && w_any && (w_grant == CH_W'(i));

        cmd_fifo #(
            .WIDTH (WORD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (in_valid[i]),
            .pop   (w_pop[i]),
            .din   ({in_cmd[i*CMD_W +: CMD_W], w_x, w_y}),
            .dout  (w_dout[i]),
            .full  (w_full[i]),
            .empty (w_empty[i])
        );
    end

    // Round-robin scan: first non-empty FIFO starting at r_rr_ptr, wrapping mod N_CH.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum   = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
            w_idx   = (w_sum >= (CH_W+1)'(N_CH)) ? CH_W'(w_sum - (CH_W+1)'(N_CH)) : w_sum[CH_W-1:0];
            w_hit   = !w_any && !w_empty[w_idx];
            w_grant = w_hit ? w_idx : w_grant;
            w_any   = w_any | w_hit;
        end
    end

    // Output register and rotation pointer; word held while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_cmd   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_ch    <= '0;
            r_rr_ptr  <= '0;
        end else if (w_load) begin
            if (w_any) begin
                out_valid                <= 1'b1;
                {out_cmd, out_x, out_y}  <= w_dout[w_grant];
                out_ch                   <= w_grant;
                r_rr_ptr                 <= w_next_rr;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky per-channel drop flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | (in_valid & w_full & ~w_pop);
        end
    end

    // Active-low LED, retriggered by every accepted push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led       <= 1'b1;
            r_led_cnt <= '0;
        end else if (w_accept) begin
            led       <= 1'b0;
            r_led_cnt <= LED_W'(LED_HOLD - 1);
        end else if (r_led_cnt != '0) begin
            r_led_cnt <= r_led_cnt - LED_W'(1);
        end else begin
            led <= 1'b1;
        end
    end

endmodule
